// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state encoding,
// the substitute fetch instruction and the wait-counter width.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } arb_state_e;

   // addi x0,x0,0 -- handed to the fetch stage when memory never answers
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // wide enough for TIMEOUT up to 2^16-1
   localparam int CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side handshake signals.
// slave: the arbiter's view. master: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              flush;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              if_stall;
   // data port
   logic              dm_rd;
   logic              dm_wr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;
   logic              dm_stall;
   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              err;

   modport slave (
      input  if_req, if_addr, flush, dm_rd, dm_wr, dm_addr, dm_wdata,
             mem_rdata, mem_done,
      output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, err
   );

   modport master (
      output if_req, if_addr, flush, dm_rd, dm_wr, dm_addr, dm_wdata,
             mem_rdata, mem_done,
      input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, err
   );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Wait-state cycle counter. tc is raised during the TIMEOUT-th consecutive
// enabled cycle, so the FSM spends exactly TIMEOUT cycles waiting before a
// forced completion. clr has priority over en.
module arb_timeout_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next count: clear wins, otherwise count while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc = en & (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// load/store. Data port has fixed priority. One outstanding transaction;
// completion on mem_done or forced after TIMEOUT wait cycles (sets err).
// Optional macro ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_if_stall,
   output logic [31:0]       perf_dm_stall
`endif
);

   arb_state_e        state_q, state_d;
   logic              discard_q, discard_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              dm_ack_q, dm_ack_d;
   logic              err_q, err_d;

   logic cnt_clr, cnt_en, cnt_tc;
   logic dm_any, dm_req_v, if_req_v, squash;
   logic if_stall_c, dm_stall_c;

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // A requester whose ack is showing this cycle is still holding its request;
   // masking it keeps the held request from being issued a second time.
   assign dm_any   = bus.dm_rd | bus.dm_wr;
   assign dm_req_v = dm_any & ~dm_ack_q;
   assign if_req_v = bus.if_req & ~if_ack_q & ~bus.flush;
   // a flush in the completion cycle squashes the fetch just like an earlier one
   assign squash   = discard_q | bus.flush;

   // next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      if_ack_d    = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_ack_d    = 1'b0;
      err_d       = err_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_clr   = 1'b1;
            discard_d = 1'b0;
            if (dm_req_v) begin
               // rd+wr together is a store
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_wr;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               state_d     = D_WAIT;
            end else if (if_req_v) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = bus.dm_wdata;
               state_d     = I_WAIT;
            end
         end

         D_WAIT: begin
            cnt_en = 1'b1;
            if (bus.mem_done) begin
               dm_rdata_d = bus.mem_rdata;
               dm_ack_d   = 1'b1;
               cnt_clr    = 1'b1;
               state_d    = IDLE;
            end else if (cnt_tc) begin
               err_d    = 1'b1;
               dm_ack_d = 1'b1;
               if (!mem_we_q)
                  dm_rdata_d = '0;
               cnt_clr  = 1'b1;
               state_d  = IDLE;
            end
         end

         I_WAIT: begin
            cnt_en = 1'b1;
            if (bus.flush)
               discard_d = 1'b1;
            if (bus.mem_done) begin
               if (!squash) begin
                  if_rdata_d = bus.mem_rdata;
                  if_ack_d   = 1'b1;
               end
               cnt_clr = 1'b1;
               state_d = IDLE;
            end else if (cnt_tc) begin
               err_d = 1'b1;
               if (!squash) begin
                  if_rdata_d = DATA_W'(NOP_INSTR);
                  if_ack_d   = 1'b1;
               end
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // state and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         discard_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_rdata_q  <= '0;
         dm_ack_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_ack_q    <= if_ack_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_ack_q    <= dm_ack_d;
         err_q       <= err_d;
      end
   end

   // stall flags are combinational so hazard logic freezes in the request cycle
   assign if_stall_c = bus.if_req & ~if_ack_q;
   assign dm_stall_c = dm_any & ~dm_ack_q;

   assign bus.if_stall  = if_stall_c;
   assign bus.dm_stall  = dm_stall_c;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.err       = err_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_q, perf_if_d;
   logic [31:0] perf_dm_q, perf_dm_d;

   // saturating stall-cycle counters; fetch stalls during a flush are not lost work
   always_comb begin
      perf_if_d = perf_if_q;
      perf_dm_d = perf_dm_q;
      if (if_stall_c && !bus.flush && perf_if_q != 32'hFFFF_FFFF)
         perf_if_d = perf_if_q + 32'd1;
      if (dm_stall_c && perf_dm_q != 32'hFFFF_FFFF)
         perf_dm_d = perf_dm_q + 32'd1;
   end

   // counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_if_q <= '0;
         perf_dm_q <= '0;
      end else begin
         perf_if_q <= perf_if_d;
         perf_dm_q <= perf_dm_d;
      end
   end

   assign perf_if_stall = perf_if_q;
   assign perf_dm_stall = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (TIMEOUT=4).
// Each row gives the inputs held for one cycle and the outputs expected in
// that same cycle; pulse fields clear automatically between rows.
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_stall, perf_dm_stall;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_stall (perf_if_stall),
      .perf_dm_stall (perf_dm_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        flush;
      logic        dm_rd;
      logic        dm_wr;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [31:0] mem_rdata;
      logic        mem_done;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic        e_iack;
      logic [31:0] e_irdata;
      logic        e_dack;
      logic [31:0] e_drdata;
      logic        e_istall;
      logic        e_dstall;
      logic        e_err;
   } vec_t;

   vec_t v;
   vec_t tbl[$];

   task automatic add();
      tbl.push_back(v);
      v.flush    = 1'b0;
      v.mem_done = 1'b0;
      v.e_mreq   = 1'b0;
      v.e_iack   = 1'b0;
      v.e_dack   = 1'b0;
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp_v);
      end
   endtask

   task automatic drive(input vec_t r);
      bus.if_req    = r.if_req;
      bus.if_addr   = r.if_addr;
      bus.flush     = r.flush;
      bus.dm_rd     = r.dm_rd;
      bus.dm_wr     = r.dm_wr;
      bus.dm_addr   = r.dm_addr;
      bus.dm_wdata  = r.dm_wdata;
      bus.mem_rdata = r.mem_rdata;
      bus.mem_done  = r.mem_done;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_mem_req"},   -1, 32'(bus.mem_req),  32'h0);
      chk({nm, "_mem_we"},    -1, 32'(bus.mem_we),   32'h0);
      chk({nm, "_mem_addr"},  -1, bus.mem_addr,      32'h0);
      chk({nm, "_mem_wdata"}, -1, bus.mem_wdata,     32'h0);
      chk({nm, "_if_ack"},    -1, 32'(bus.if_ack),   32'h0);
      chk({nm, "_if_rdata"},  -1, bus.if_rdata,      32'h0);
      chk({nm, "_dm_ack"},    -1, 32'(bus.dm_ack),   32'h0);
      chk({nm, "_dm_rdata"},  -1, bus.dm_rdata,      32'h0);
      chk({nm, "_err"},       -1, 32'(bus.err),      32'h0);
   endtask

   initial begin
      vec_t z;
      z = '{if_req:0, if_addr:0, flush:0, dm_rd:0, dm_wr:0, dm_addr:0, dm_wdata:0,
            mem_rdata:0, mem_done:0, e_mreq:0, e_mwe:0, e_maddr:0, e_mwdata:0,
            e_iack:0, e_irdata:0, e_dack:0, e_drdata:0, e_istall:0, e_dstall:0, e_err:0};
      v = z;

      // fetch only, mem_done two cycles after mem_req
      v.if_req = 1; v.if_addr = 32'h40; v.e_istall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h40; add();
      add();
      v.mem_done = 1; v.mem_rdata = 32'h00500093; add();
      v.e_iack = 1; v.e_irdata = 32'h00500093; v.e_istall = 0; add();
      v.if_req = 0; add();
      // simultaneous fetch and load: load first, fetch the cycle after dm_ack
      v.if_req = 1; v.if_addr = 32'h44; v.dm_rd = 1; v.dm_addr = 32'h100;
      v.e_istall = 1; v.e_dstall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h100; add();
      v.mem_done = 1; v.mem_rdata = 32'h11112222; add();
      v.e_dack = 1; v.e_drdata = 32'h11112222; v.e_dstall = 0; add();
      v.dm_rd = 0; v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h44; add();
      v.mem_done = 1; v.mem_rdata = 32'h22223333; add();
      v.e_iack = 1; v.e_irdata = 32'h22223333; v.e_istall = 0; add();
      v.if_req = 0; add();
      // store held through ack; address/data changes after grant ignored
      v.dm_wr = 1; v.dm_addr = 32'h200; v.dm_wdata = 32'hDEADBEEF; v.e_dstall = 1; add();
      v.dm_addr = 32'h300; v.dm_wdata = 32'h0;
      v.e_mreq = 1; v.e_mwe = 1; v.e_maddr = 32'h200; v.e_mwdata = 32'hDEADBEEF; add();
      v.mem_done = 1; v.mem_rdata = 32'hAAAA5555; add();
      v.e_dack = 1; v.e_drdata = 32'hAAAA5555; v.e_dstall = 0; add();
      v.dm_wr = 0; add();
      // rd and wr together act as a store
      v.dm_rd = 1; v.dm_wr = 1; v.dm_addr = 32'h204; v.dm_wdata = 32'h12345678; v.e_dstall = 1; add();
      v.e_mreq = 1; v.e_mwe = 1; v.e_maddr = 32'h204; v.e_mwdata = 32'h12345678; add();
      v.mem_done = 1; v.mem_rdata = 32'h0BADF00D; add();
      v.e_dack = 1; v.e_drdata = 32'h0BADF00D; v.e_dstall = 0; add();
      v.dm_rd = 0; v.dm_wr = 0; add();
      // flush during I_WAIT: no ack, rdata kept, next fetch to 0x80 normal
      v.if_req = 1; v.if_addr = 32'h60; v.e_istall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h60; add();
      v.flush = 1; v.if_addr = 32'h80; add();
      v.mem_done = 1; v.mem_rdata = 32'hBADBAD00; add();
      add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h80; add();
      v.mem_done = 1; v.mem_rdata = 32'h00000093; add();
      v.e_iack = 1; v.e_irdata = 32'h00000093; v.e_istall = 0; add();
      v.if_req = 0; add();
      // flush in IDLE blocks the fetch grant for that cycle
      v.if_req = 1; v.if_addr = 32'h84; v.flush = 1; v.e_istall = 1; add();
      add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h84; add();
      v.mem_done = 1; v.mem_rdata = 32'h13579BDF; add();
      v.e_iack = 1; v.e_irdata = 32'h13579BDF; v.e_istall = 0; add();
      v.if_req = 0; add();
      // mem_done in the last wait cycle: normal completion, no err
      v.dm_rd = 1; v.dm_addr = 32'h300; v.e_dstall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h300; add();
      add();
      add();
      v.mem_done = 1; v.mem_rdata = 32'h55AA55AA; add();
      v.e_dack = 1; v.e_drdata = 32'h55AA55AA; v.e_dstall = 0; add();
      v.dm_rd = 0; add();
      // fetch timeout: NOP after 4 wait cycles, err sticky, late done ignored
      v.if_req = 1; v.if_addr = 32'h90; v.e_istall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h90; add();
      add();
      add();
      add();
      v.e_iack = 1; v.e_irdata = 32'h00000013; v.e_istall = 0; v.e_err = 1; add();
      v.if_req = 0; v.mem_done = 1; v.mem_rdata = 32'hFFFFFFFF; add();
      add();
      // load timeout: substitute data is zero
      v.dm_rd = 1; v.dm_addr = 32'h310; v.e_dstall = 1; add();
      v.e_mreq = 1; v.e_mwe = 0; v.e_maddr = 32'h310; add();
      add();
      add();
      add();
      v.e_dack = 1; v.e_drdata = 32'h0; v.e_dstall = 0; add();
      v.dm_rd = 0; add();

      // reset state
      reset = 1'b1;
      drive(z);
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk("mem_req",  i, 32'(bus.mem_req),  32'(tbl[i].e_mreq));
         chk("if_ack",   i, 32'(bus.if_ack),   32'(tbl[i].e_iack));
         chk("dm_ack",   i, 32'(bus.dm_ack),   32'(tbl[i].e_dack));
         chk("if_stall", i, 32'(bus.if_stall), 32'(tbl[i].e_istall));
         chk("dm_stall", i, 32'(bus.dm_stall), 32'(tbl[i].e_dstall));
         chk("err",      i, 32'(bus.err),      32'(tbl[i].e_err));
         chk("if_rdata", i, bus.if_rdata,      tbl[i].e_irdata);
         chk("dm_rdata", i, bus.dm_rdata,      tbl[i].e_drdata);
         if (tbl[i].e_mreq) begin
            chk("mem_we",   i, 32'(bus.mem_we), 32'(tbl[i].e_mwe));
            chk("mem_addr", i, bus.mem_addr,    tbl[i].e_maddr);
            if (tbl[i].e_mwe)
               chk("mem_wdata", i, bus.mem_wdata, tbl[i].e_mwdata);
         end
      end

      // asynchronous reset in the middle of a D_WAIT store
      @(negedge clk);
      drive(z);
      bus.dm_wr = 1'b1; bus.dm_addr = 32'h400; bus.dm_wdata = 32'hCAFEF00D;
      @(negedge clk);
      #1;
      chk("rst_pre_mem_req",  -1, 32'(bus.mem_req), 32'h1);
      chk("rst_pre_mem_addr", -1, bus.mem_addr,     32'h400);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      bus.dm_wr = 1'b0;
      bus.mem_done = 1'b1; bus.mem_rdata = 32'h00000077;
      @(negedge clk);
      bus.mem_done = 1'b0;
      #1;
      chk("rst_late_dm_ack",   -1, 32'(bus.dm_ack), 32'h0);
      chk("rst_late_dm_rdata", -1, bus.dm_rdata,    32'h0);
      chk("rst_late_mem_req",  -1, 32'(bus.mem_req), 32'h0);
      // arbiter back in IDLE: a fresh fetch issues at once
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h500;
      @(negedge clk);
      #1;
      chk("rst_after_mem_req",  -1, 32'(bus.mem_req), 32'h1);
      chk("rst_after_mem_addr", -1, bus.mem_addr,     32'h500);
      chk("rst_after_err",      -1, 32'(bus.err),     32'h0);
      bus.if_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
